asm_loop_ctrl: RTL and testbench

//  Parametrised ASM control unit: start/step/finish loop sequencer with Mealy enables.

---
 rtl/asm_loop_ctrl.sv | 118 +++++++++++
 tb/tb_asm_loop_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asm_loop_ctrl.sv
// ASM start/step/finish loop sequencer with Mealy enables, hold, iteration-limit timeout
// and a cool-down gap before the next start can be accepted.
module asm_loop_ctrl #(
    parameter int DATA_W    = 32,
    parameter int COND_MODE = 0,
    parameter int MAX_ITER  = 16,
    parameter int CNT_W     = 8,
    parameter int GAP       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic [DATA_W-1:0] cond_start,
    input  logic [DATA_W-1:0] cond_done,
    output logic              en_load,
    output logic              en_step,
    output logic              en_finish,
    output logic              busy,
    output logic              timeout,
    output logic [CNT_W-1:0]  iter_cnt,
    output logic [1:0]        state_o
);
    localparam int GW = (GAP < 2) ? 1 : $clog2(GAP + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, WAIT = 2'd2} state_t;

    // A zero gap skips WAIT entirely, so the run exits straight to IDLE.
    localparam state_t EXIT_ST = (GAP == 0) ? IDLE : WAIT;

    state_t            state_q;
    logic [CNT_W-1:0]  iter_q;
    logic [GW-1:0]     gap_q;
    logic              timeout_q;
    logic              busy_q;

    function automatic logic cond_true(input logic [DATA_W-1:0] w);
        if (COND_MODE != 0) return w != '0;
        else                return w == DATA_W'(1);
    endfunction

    logic start_ok, done_ok, last_step;
    assign start_ok  = cond_true(cond_start);
    assign done_ok   = cond_true(cond_done);
    assign last_step = (iter_q == CNT_W'(MAX_ITER - 1));

    always_comb begin
        en_load   = 1'b0;
        en_step   = 1'b0;
        en_finish = 1'b0;
        if (rst && !hold) begin
            case (state_q)
                IDLE:    en_load = start_ok;
                RUN: begin
                    if (done_ok) en_finish = 1'b1;
                    else         en_step   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            iter_q    <= '0;
            gap_q     <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en_load) begin
                        state_q   <= RUN;
                        iter_q    <= '0;
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                RUN: begin
                    if (en_finish) begin
                        state_q <= EXIT_ST;
                        gap_q   <= GW'(GAP);
                        busy_q  <= (GAP != 0);
                    end else if (en_step) begin
                        iter_q <= iter_q + 1'b1;
                        if (last_step) begin
                            timeout_q <= 1'b1;
                            state_q   <= EXIT_ST;
                            gap_q     <= GW'(GAP);
                            busy_q    <= (GAP != 0);
                        end
                    end
                end
                WAIT: begin
                    if (!hold) begin
                        if (gap_q <= GW'(1)) begin
                            state_q <= IDLE;
                            gap_q   <= '0;
                            busy_q  <= 1'b0;
                        end else begin
                            gap_q <= gap_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign timeout  = timeout_q;
    assign iter_cnt = iter_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_asm_loop_ctrl.sv
// Bench for asm_loop_ctrl: three builds (default, COND_MODE=1, GAP=0/MAX_ITER=4) on shared inputs,
// per-cycle expected outputs queued at drive time and compared at the falling edge.
module tb_asm_loop_ctrl;
    typedef struct packed {
        logic       ld;
        logic       stp;
        logic       fin;
        logic       bz;
        logic       to;
        logic [7:0] it;
        logic [1:0] st;
    } obs_t;

    typedef struct {
        bit          r;
        bit          h;
        logic [31:0] s;
        logic [31:0] d;
        int          inst;
        bit          chk;
        obs_t        e;
    } row_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hold = 1'b0;
    logic [31:0] cond_start = '0;
    logic [31:0] cond_done = '0;

    logic       en_load [3];
    logic       en_step [3];
    logic       en_finish [3];
    logic       busy [3];
    logic       timeout [3];
    logic [7:0] iter_cnt [3];
    logic [1:0] state_o [3];
    obs_t       obs [3];

    row_t stim [$];
    row_t expq [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    asm_loop_ctrl #(.DATA_W(32), .COND_MODE(0), .MAX_ITER(16), .CNT_W(8), .GAP(2)) u_def (
        .clk(clk), .rst(rst), .hold(hold), .cond_start(cond_start), .cond_done(cond_done),
        .en_load(en_load[0]), .en_step(en_step[0]), .en_finish(en_finish[0]), .busy(busy[0]),
        .timeout(timeout[0]), .iter_cnt(iter_cnt[0]), .state_o(state_o[0]));

    asm_loop_ctrl #(.DATA_W(32), .COND_MODE(1), .MAX_ITER(16), .CNT_W(8), .GAP(2)) u_m1 (
        .clk(clk), .rst(rst), .hold(hold), .cond_start(cond_start), .cond_done(cond_done),
        .en_load(en_load[1]), .en_step(en_step[1]), .en_finish(en_finish[1]), .busy(busy[1]),
        .timeout(timeout[1]), .iter_cnt(iter_cnt[1]), .state_o(state_o[1]));

    asm_loop_ctrl #(.DATA_W(32), .COND_MODE(0), .MAX_ITER(4), .CNT_W(8), .GAP(0)) u_g0 (
        .clk(clk), .rst(rst), .hold(hold), .cond_start(cond_start), .cond_done(cond_done),
        .en_load(en_load[2]), .en_step(en_step[2]), .en_finish(en_finish[2]), .busy(busy[2]),
        .timeout(timeout[2]), .iter_cnt(iter_cnt[2]), .state_o(state_o[2]));

    for (genvar k = 0; k < 3; k++) begin : g_obs
        assign obs[k] = {en_load[k], en_step[k], en_finish[k], busy[k], timeout[k],
                         iter_cnt[k], state_o[k]};
    end

    function automatic obs_t ex(input bit l, input bit s, input bit f, input bit b, input bit t,
                                input int it, input int st);
        obs_t o;
        o = {l, s, f, b, t, 8'(it), 2'(st)};
        return o;
    endfunction

    function automatic void add(input bit r, input bit h, input logic [31:0] s,
                                input logic [31:0] d, input int inst, input bit chk,
                                input obs_t e);
        row_t x;
        x.r = r; x.h = h; x.s = s; x.d = d; x.inst = inst; x.chk = chk; x.e = e;
        stim.push_back(x);
    endfunction

    task automatic test_reset;
        row_t r, e;
        obs_t got;
        int   idx = 0;
        add(0, 0, 1, 0, 0, 1, ex(0, 0, 0, 0, 0, 0, 0));
        add(0, 0, 1, 0, 0, 1, ex(0, 0, 0, 0, 0, 0, 0));
        while (stim.size() > 0) begin
            r = stim.pop_front();
            @(posedge clk); #1;
            rst = r.r; hold = r.h; cond_start = r.s; cond_done = r.d;
            if (r.chk) expq.push_back(r);
            @(negedge clk);
            if (r.chk) begin
                e = expq.pop_front(); got = obs[e.inst]; n_cmp++;
                if (got !== e.e) begin
                    n_bad++;
                    $display("FAIL reset row %0d: got %h want %h", idx, got, e.e);
                end
            end
            idx++;
        end
    endtask

    task automatic test_normal;
        row_t r, e;
        obs_t got;
        int   idx = 0;
        add(1, 0, 1, 0, 0, 1, ex(1, 0, 0, 0, 0, 0, 0));
        add(1, 0, 0, 0, 0, 1, ex(0, 1, 0, 1, 0, 0, 1));
        add(1, 0, 0, 0, 0, 1, ex(0, 1, 0, 1, 0, 1, 1));
        add(1, 0, 0, 0, 0, 1, ex(0, 1, 0, 1, 0, 2, 1));
        add(1, 0, 0, 1, 0, 1, ex(0, 0, 1, 1, 0, 3, 1));
        add(1, 0, 0, 0, 0, 1, ex(0, 0, 0, 1, 0, 3, 2));
        add(1, 0, 0, 0, 0, 1, ex(0, 0, 0, 1, 0, 3, 2));
        add(1, 0, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 3, 0));
        while (stim.size() > 0) begin
            r = stim.pop_front();
            @(posedge clk); #1;
            rst = r.r; hold = r.h; cond_start = r.s; cond_done = r.d;
            if (r.chk) expq.push_back(r);
            @(negedge clk);
            if (r.chk) begin
                e = expq.pop_front(); got = obs[e.inst]; n_cmp++;
                if (got !== e.e) begin
                    n_bad++;
                    $display("FAIL normal row %0d: got %h want %h", idx, got, e.e);
                end
            end
            idx++;
        end
    endtask

    task automatic test_timeout;
        row_t r, e;
        obs_t got;
        int   idx = 0;
        add(1, 0, 1, 0, 0, 1, ex(1, 0, 0, 0, 0, 3, 0));
        for (int i = 0; i < 16; i++) add(1, 0, 0, 0, 0, 1, ex(0, 1, 0, 1, 0, i, 1));
        add(1, 0, 0, 0, 0, 1, ex(0, 0, 0, 1, 1, 16, 2));
        add(1, 0, 0, 0, 0, 1, ex(0, 0, 0, 1, 1, 16, 2));
        add(1, 0, 1, 0, 0, 1, ex(1, 0, 0, 0, 1, 16, 0));
        add(1, 0, 0, 1, 0, 1, ex(0, 0, 1, 1, 0, 0, 1));
        add(1, 0, 0, 0, 0, 1, ex(0, 0, 0, 1, 0, 0, 2));
        add(1, 0, 0, 0, 0, 1, ex(0, 0, 0, 1, 0, 0, 2));
        add(1, 0, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 0, 0));
        while (stim.size() > 0) begin
            r = stim.pop_front();
            @(posedge clk); #1;
            rst = r.r; hold = r.h; cond_start = r.s; cond_done = r.d;
            if (r.chk) expq.push_back(r);
            @(negedge clk);
            if (r.chk) begin
                e = expq.pop_front(); got = obs[e.inst]; n_cmp++;
                if (got !== e.e) begin
                    n_bad++;
                    $display("FAIL timeout row %0d: got %h want %h", idx, got, e.e);
                end
            end
            idx++;
        end
    endtask

    task automatic test_hold;
        row_t r, e;
        obs_t got;
        int   idx = 0;
        add(1, 1, 1, 0, 0, 1, ex(0, 0, 0, 0, 0, 0, 0));
        add(1, 0, 1, 0, 0, 1, ex(1, 0, 0, 0, 0, 0, 0));
        add(1, 0, 0, 0, 0, 1, ex(0, 1, 0, 1, 0, 0, 1));
        add(1, 0, 0, 0, 0, 1, ex(0, 1, 0, 1, 0, 1, 1));
        for (int i = 0; i < 3; i++) add(1, 1, 0, 1, 0, 1, ex(0, 0, 0, 1, 0, 2, 1));
        add(1, 0, 0, 1, 0, 1, ex(0, 0, 1, 1, 0, 2, 1));
        add(1, 1, 1, 0, 0, 1, ex(0, 0, 0, 1, 0, 2, 2));
        add(1, 0, 1, 0, 0, 1, ex(0, 0, 0, 1, 0, 2, 2));
        add(1, 0, 0, 0, 0, 1, ex(0, 0, 0, 1, 0, 2, 2));
        add(1, 0, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 2, 0));
        add(1, 0, 1, 0, 0, 1, ex(1, 0, 0, 0, 0, 2, 0));
        for (int i = 0; i < 15; i++) add(1, 0, 0, 0, 0, 1, ex(0, 1, 0, 1, 0, i, 1));
        add(1, 0, 0, 1, 0, 1, ex(0, 0, 1, 1, 0, 15, 1));
        add(1, 0, 0, 0, 0, 1, ex(0, 0, 0, 1, 0, 15, 2));
        add(1, 0, 0, 0, 0, 1, ex(0, 0, 0, 1, 0, 15, 2));
        add(1, 0, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 15, 0));
        while (stim.size() > 0) begin
            r = stim.pop_front();
            @(posedge clk); #1;
            rst = r.r; hold = r.h; cond_start = r.s; cond_done = r.d;
            if (r.chk) expq.push_back(r);
            @(negedge clk);
            if (r.chk) begin
                e = expq.pop_front(); got = obs[e.inst]; n_cmp++;
                if (got !== e.e) begin
                    n_bad++;
                    $display("FAIL hold row %0d: got %h want %h", idx, got, e.e);
                end
            end
            idx++;
        end
    endtask

    task automatic test_cond_mode;
        row_t r, e;
        obs_t got;
        int   idx = 0;
        add(1, 0, 32'h2, 0, 0, 1, ex(0, 0, 0, 0, 0, 15, 0));
        add(1, 0, 32'hFFFF_FFFF, 0, 0, 1, ex(0, 0, 0, 0, 0, 15, 0));
        add(1, 0, 32'h8000_0001, 0, 0, 1, ex(0, 0, 0, 0, 0, 15, 0));
        add(0, 0, 0, 0, 1, 0, ex(0, 0, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, 1, 1, ex(0, 0, 0, 0, 0, 0, 0));
        add(1, 0, 32'h2, 0, 1, 1, ex(1, 0, 0, 0, 0, 0, 0));
        add(1, 0, 0, 0, 1, 1, ex(0, 1, 0, 1, 0, 0, 1));
        add(1, 0, 0, 32'h4, 1, 1, ex(0, 0, 1, 1, 0, 1, 1));
        add(1, 0, 0, 0, 1, 1, ex(0, 0, 0, 1, 0, 1, 2));
        add(1, 0, 0, 0, 1, 1, ex(0, 0, 0, 1, 0, 1, 2));
        add(1, 0, 0, 0, 1, 1, ex(0, 0, 0, 0, 0, 1, 0));
        while (stim.size() > 0) begin
            r = stim.pop_front();
            @(posedge clk); #1;
            rst = r.r; hold = r.h; cond_start = r.s; cond_done = r.d;
            if (r.chk) expq.push_back(r);
            @(negedge clk);
            if (r.chk) begin
                e = expq.pop_front(); got = obs[e.inst]; n_cmp++;
                if (got !== e.e) begin
                    n_bad++;
                    $display("FAIL cond_mode row %0d: got %h want %h", idx, got, e.e);
                end
            end
            idx++;
        end
    endtask

    task automatic test_midrun_reset;
        row_t r, e;
        obs_t got;
        int   idx = 0;
        add(1, 0, 1, 0, 0, 1, ex(1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 1, ex(0, 1, 0, 1, 0, i, 1));
        add(0, 0, 0, 1, 0, 1, ex(0, 0, 0, 1, 0, 5, 1));
        add(1, 0, 0, 1, 0, 1, ex(0, 0, 0, 0, 0, 0, 0));
        while (stim.size() > 0) begin
            r = stim.pop_front();
            @(posedge clk); #1;
            rst = r.r; hold = r.h; cond_start = r.s; cond_done = r.d;
            if (r.chk) expq.push_back(r);
            @(negedge clk);
            if (r.chk) begin
                e = expq.pop_front(); got = obs[e.inst]; n_cmp++;
                if (got !== e.e) begin
                    n_bad++;
                    $display("FAIL midrun_reset row %0d: got %h want %h", idx, got, e.e);
                end
            end
            idx++;
        end
    endtask

    task automatic test_back_to_back;
        row_t r, e;
        obs_t got;
        int   idx = 0;
        add(0, 0, 0, 0, 2, 0, ex(0, 0, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, 2, 1, ex(0, 0, 0, 0, 0, 0, 0));
        add(1, 0, 1, 0, 2, 1, ex(1, 0, 0, 0, 0, 0, 0));
        add(1, 0, 0, 0, 2, 1, ex(0, 1, 0, 1, 0, 0, 1));
        add(1, 0, 0, 1, 2, 1, ex(0, 0, 1, 1, 0, 1, 1));
        add(1, 0, 1, 0, 2, 1, ex(1, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 2, 1, ex(0, 1, 0, 1, 0, i, 1));
        add(1, 0, 0, 0, 2, 1, ex(0, 0, 0, 0, 1, 4, 0));
        while (stim.size() > 0) begin
            r = stim.pop_front();
            @(posedge clk); #1;
            rst = r.r; hold = r.h; cond_start = r.s; cond_done = r.d;
            if (r.chk) expq.push_back(r);
            @(negedge clk);
            if (r.chk) begin
                e = expq.pop_front(); got = obs[e.inst]; n_cmp++;
                if (got !== e.e) begin
                    n_bad++;
                    $display("FAIL back_to_back row %0d: got %h want %h", idx, got, e.e);
                end
            end
            idx++;
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_timeout();
        test_hold();
        test_cond_mode();
        test_midrun_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
